// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// Two-requester arbiter onto one single-ported data memory; writes take one cycle, reads two.
// Tie breaking is fixed priority (port 0) unless DMEM_ARB_RR_EN is defined (round-robin).
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module dmem_arbiter (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   p0_valid,
  input  logic                   p0_we,
  input  logic [`WORD_WIDTH-1:0] p0_addr,
  input  logic [`WORD_WIDTH-1:0] p0_wdata,
  input  logic                   p1_valid,
  input  logic                   p1_we,
  input  logic [`WORD_WIDTH-1:0] p1_addr,
  input  logic [`WORD_WIDTH-1:0] p1_wdata,
  output logic                   p0_ready,
  output logic                   p1_ready,
  output logic                   p0_rvalid,
  output logic                   p1_rvalid,
  output logic [`WORD_WIDTH-1:0] p0_rdata,
  output logic [`WORD_WIDTH-1:0] p1_rdata,
  output logic                   mem_write,
  output logic                   mem_read,
  output logic [`WORD_WIDTH-1:0] mem_addr,
  output logic [`WORD_WIDTH-1:0] mem_wdata,
  input  logic [`WORD_WIDTH-1:0] mem_rdata
);

  localparam int W = `WORD_WIDTH;

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           owner_q, owner_d;

  logic           any_req;
  logic           grant;
  logic           winner;
  logic           win_we;
  logic [W-1:0]   win_addr;
  logic [W-1:0]   win_wdata;

  assign any_req = p0_valid | p1_valid;
  // Reset masks the grant combinationally so nothing is accepted while rst is high.
  assign grant   = ~rst & (state_q == IDLE) & any_req;

  always_comb begin
    winner = p1_valid & ~p0_valid;
    if (p0_valid && p1_valid) begin
`ifdef DMEM_ARB_RR_EN
      winner = ~last_grant_q;
`else
      winner = 1'b0;
`endif
    end
  end

`ifndef DMEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  assign win_we    = winner ? p1_we    : p0_we;
  assign win_addr  = winner ? p1_addr  : p0_addr;
  assign win_wdata = winner ? p1_wdata : p0_wdata;

  assign p0_ready  = grant & ~winner;
  assign p1_ready  = grant &  winner;
  assign mem_write = grant &  win_we;
  assign mem_read  = grant & ~win_we;
  assign mem_addr  = grant ? win_addr  : '0;
  assign mem_wdata = grant ? win_wdata : '0;

  // Read data is broadcast; only the owner of the outstanding read sees rvalid.
  assign p0_rvalid = (state_q == RD_WAIT) & ~owner_q;
  assign p1_rvalid = (state_q == RD_WAIT) &  owner_q;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          last_grant_d = winner;
          if (!win_we) begin
            state_d = RD_WAIT;
            owner_d = winner;
          end
        end
      end
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_write && mem_read));
      assert (!(p0_ready && p1_ready));
      assert (!(p0_rvalid && p1_rvalid));
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model and a behavioural memory.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_dmem_arbiter;

  localparam int W = `WORD_WIDTH;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         p0_valid = 1'b0, p0_we = 1'b0, p1_valid = 1'b0, p1_we = 1'b0;
  logic [W-1:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic         p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic [W-1:0] p0_rdata, p1_rdata;
  logic         mem_write, mem_read;
  logic [W-1:0] mem_addr, mem_wdata;
  logic [W-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] emu [16] = '{default: '0};
  logic [W-1:0] ref_mem [16];
  logic         m_last;

  wire [5:0] st = {p0_ready, p1_ready, mem_write, mem_read, p0_rvalid, p1_rvalid};

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: synchronous write, read data returned the cycle after mem_read.
  always @(posedge clk) begin
    if (mem_write) emu[mem_addr[3:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= emu[mem_addr[3:0]];
  end

  task automatic test_reset();
    rst = 1'b1;
    p0_valid = 1'b1; p1_valid = 1'b1; p0_we = 1'b1; p1_we = 1'b0;
    p0_addr = W'(7); p1_addr = W'(9); p0_wdata = W'(32'h1234); p1_wdata = W'(32'h5678);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    n_checks++;
    if (st !== 6'b0) begin n_fail++; $display("FAIL reset_status got %b want %b", st, 6'b0); end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++; $display("FAIL reset_bus got addr %0h wdata %0h want 0 0", mem_addr, mem_wdata);
    end
    m_last = 1'b1;
    @(negedge clk);
    rst = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0; #2;
    n_checks++;
    if (st !== 6'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++; $display("FAIL idle_no_grant got st %b addr %0h wdata %0h want 0 0 0", st, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = W'(5); p0_wdata = W'(32'hDEADBEEF); #2;
    n_checks++;
    if (st !== 6'b101000) begin n_fail++; $display("FAIL wr_grant got %b want %b", st, 6'b101000); end
    n_checks++;
    if (mem_addr !== W'(5) || mem_wdata !== W'(32'hDEADBEEF)) begin
      n_fail++; $display("FAIL wr_bus got %0h/%0h want 5/deadbeef", mem_addr, mem_wdata);
    end
    ref_mem[5] = W'(32'hDEADBEEF); m_last = 1'b0;
    @(negedge clk);
    p0_valid = 1'b0;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = W'(5); p1_wdata = W'(32'h0BAD); #2;
    n_checks++;
    if (st !== 6'b010100) begin n_fail++; $display("FAIL rd_grant got %b want %b", st, 6'b010100); end
    n_checks++;
    if (mem_addr !== W'(5) || mem_wdata !== W'(32'h0BAD)) begin
      n_fail++; $display("FAIL rd_bus got %0h/%0h want 5/bad", mem_addr, mem_wdata);
    end
    m_last = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0; #2;
    n_checks++;
    if (st !== 6'b000001) begin n_fail++; $display("FAIL rd_rvalid got %b want %b", st, 6'b000001); end
    n_checks++;
    if (p1_rdata !== W'(32'hDEADBEEF)) begin
      n_fail++; $display("FAIL rd_data got %0h want deadbeef", p1_rdata);
    end
    @(negedge clk); #2;
    n_checks++;
    if (st !== 6'b0) begin n_fail++; $display("FAIL rd_done got %b want %b", st, 6'b0); end
  endtask

  task automatic test_contention_writes();
    logic       w;
    logic [5:0] want;
    int         prev = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (prev != 1) begin p0_addr = W'($urandom_range(15)); p0_wdata = W'($urandom); end
      if (prev != 0) begin p1_addr = W'($urandom_range(15)); p1_wdata = W'($urandom); end
      p0_valid = 1'b1; p1_valid = 1'b1; p0_we = 1'b1; p1_we = 1'b1; #2;
      w = RR ? ~m_last : 1'b0;
      want = {~w, w, 1'b1, 1'b0, 2'b00};
      n_checks++;
      if (st !== want) begin n_fail++; $display("FAIL contend_grant[%0d] got %b want %b", i, st, want); end
      n_checks++;
      if (mem_addr !== (w ? p1_addr : p0_addr) || mem_wdata !== (w ? p1_wdata : p0_wdata)) begin
        n_fail++; $display("FAIL contend_bus[%0d] got %0h/%0h want %0h/%0h", i, mem_addr, mem_wdata,
                           w ? p1_addr : p0_addr, w ? p1_wdata : p0_wdata);
      end
      ref_mem[w ? p1_addr[3:0] : p0_addr[3:0]] = w ? p1_wdata : p0_wdata;
      m_last = w;
      prev = int'(w);
    end
    @(negedge clk);
    p0_valid = 1'b0; p1_valid = 1'b0;
  endtask

  task automatic test_back_to_back_reads();
    logic         w, own;
    logic [5:0]   want;
    logic [W-1:0] exp_rd;
    own = 1'b0; exp_rd = '0;
    p0_valid = 1'b1; p1_valid = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = W'(5); p1_addr = W'($urandom_range(15));
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i % 2 == 1) begin
        if (own) p1_addr = W'($urandom_range(15));
        else     p0_addr = W'($urandom_range(15));
      end
      #2;
      if (i % 2 == 0) begin
        w = RR ? ~m_last : 1'b0;
        want = {~w, w, 1'b0, 1'b1, 2'b00};
        n_checks++;
        if (st !== want) begin n_fail++; $display("FAIL b2b_grant[%0d] got %b want %b", i, st, want); end
        n_checks++;
        if (mem_addr !== (w ? p1_addr : p0_addr)) begin
          n_fail++; $display("FAIL b2b_addr[%0d] got %0h want %0h", i, mem_addr, w ? p1_addr : p0_addr);
        end
        exp_rd = ref_mem[w ? p1_addr[3:0] : p0_addr[3:0]];
        m_last = w; own = w;
      end else begin
        want = {4'b0000, ~own, own};
        n_checks++;
        if (st !== want) begin n_fail++; $display("FAIL b2b_wait[%0d] got %b want %b", i, st, want); end
        n_checks++;
        if (p0_rdata !== exp_rd || p1_rdata !== exp_rd) begin
          n_fail++; $display("FAIL b2b_rdata[%0d] got %0h/%0h want %0h", i, p0_rdata, p1_rdata, exp_rd);
        end
      end
    end
    @(negedge clk);
    p0_valid = 1'b0; p1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = W'(5); p1_valid = 1'b0; #2;
    n_checks++;
    if (st !== 6'b100100) begin n_fail++; $display("FAIL rst_rd_grant got %b want %b", st, 6'b100100); end
    m_last = 1'b0;
    @(posedge clk); #2;
    p0_valid = 1'b0;
    n_checks++;
    if (st !== 6'b000010) begin n_fail++; $display("FAIL rst_rd_wait got %b want %b", st, 6'b000010); end
    p0_valid = 1'b1; p1_valid = 1'b1; p0_we = 1'b1; p1_we = 1'b1;
    p0_addr = W'(3); p0_wdata = W'($urandom); p1_addr = W'(4); p1_wdata = W'($urandom);
    rst = 1'b1; #1;
    n_checks++;
    if (st !== 6'b0) begin n_fail++; $display("FAIL rst_async got %b want %b", st, 6'b0); end
    m_last = 1'b1;
    @(negedge clk); #2;
    n_checks++;
    if (st !== 6'b0) begin n_fail++; $display("FAIL rst_held got %b want %b", st, 6'b0); end
    @(negedge clk);
    rst = 1'b0; #2;
    n_checks++;
    if (st !== 6'b101000 || mem_addr !== W'(3)) begin
      n_fail++; $display("FAIL rst_release got %b addr %0h want %b addr 3", st, mem_addr, 6'b101000);
    end
    ref_mem[3] = p0_wdata; m_last = 1'b0;
    @(negedge clk);
    p0_valid = 1'b0; #2;
    n_checks++;
    if (st !== 6'b011000 || mem_addr !== W'(4)) begin
      n_fail++; $display("FAIL rst_after got %b addr %0h want %b addr 4", st, mem_addr, 6'b011000);
    end
    ref_mem[4] = p1_wdata; m_last = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0; #2;
    n_checks++;
    if (st !== 6'b0) begin n_fail++; $display("FAIL rst_quiet got %b want %b", st, 6'b0); end
  endtask

  task automatic test_random();
    logic         rq_v [2], rq_we [2];
    logic [W-1:0] rq_a [2], rq_d [2];
    logic         m_pend, m_own, w, granted;
    logic [W-1:0] m_exp, exp_addr, exp_wd;
    logic [5:0]   want;
    m_pend = 1'b0; m_own = 1'b0; m_exp = '0; w = 1'b0;
    for (int p = 0; p < 2; p++) begin rq_v[p] = 1'b0; rq_we[p] = 1'b0; rq_a[p] = '0; rq_d[p] = '0; end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!rq_v[p] && $urandom_range(9) < 6) begin
          rq_v[p] = 1'b1; rq_we[p] = 1'($urandom_range(1));
          rq_a[p] = W'($urandom_range(15)); rq_d[p] = W'($urandom);
        end
      end
      p0_valid = rq_v[0]; p0_we = rq_we[0]; p0_addr = rq_a[0]; p0_wdata = rq_d[0];
      p1_valid = rq_v[1]; p1_we = rq_we[1]; p1_addr = rq_a[1]; p1_wdata = rq_d[1];
      #2;
      want = '0; exp_addr = '0; exp_wd = '0; granted = 1'b0;
      if (m_pend) begin
        want = m_own ? 6'b000001 : 6'b000010;
      end else if (rq_v[0] || rq_v[1]) begin
        w = (rq_v[0] && rq_v[1]) ? (RR ? ~m_last : 1'b0) : rq_v[1];
        want = {~w, w, rq_we[w], ~rq_we[w], 2'b00};
        exp_addr = rq_a[w]; exp_wd = rq_d[w]; granted = 1'b1;
      end
      n_checks++;
      if (st !== want) begin n_fail++; $display("FAIL rand_status[%0d] got %b want %b", c, st, want); end
      n_checks++;
      if (mem_addr !== exp_addr || mem_wdata !== exp_wd) begin
        n_fail++; $display("FAIL rand_bus[%0d] got %0h/%0h want %0h/%0h", c, mem_addr, mem_wdata, exp_addr, exp_wd);
      end
      if (m_pend) begin
        n_checks++;
        if (p0_rdata !== m_exp || p1_rdata !== m_exp) begin
          n_fail++; $display("FAIL rand_rdata[%0d] got %0h/%0h want %0h", c, p0_rdata, p1_rdata, m_exp);
        end
        m_pend = 1'b0;
      end else if (granted) begin
        m_last = w;
        if (rq_we[w]) ref_mem[rq_a[w][3:0]] = rq_d[w];
        else begin m_pend = 1'b1; m_own = w; m_exp = ref_mem[rq_a[w][3:0]]; end
        rq_v[w] = 1'b0;
      end
    end
    @(negedge clk);
    p0_valid = 1'b0; p1_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    m_last = 1'b1;
    test_reset();
    test_write_read();
    test_contention_writes();
    test_back_to_back_reads();
    test_reset_mid_read();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
